// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the ID/EX stage: data/register widths, ALU opcodes,
// ID/EX FSM states and the packed ID/EX payload with its bubble value.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    HALTED = 2'd2
  } idex_state_t;

  typedef struct packed {
    word_t       npc;
    logic        dren;
    logic        dwen;
    logic        regwr;
    logic [2:0]  regsel;
    regbits_t    regdst;
    regbits_t    rs;
    regbits_t    rt;
    word_t       rdat1;
    word_t       rdat2;
    word_t       imm;
    word_t       shamt;
    aluop_t      aluop;
    logic [2:0]  alusrc;
    logic        halt;
    word_t       lui;
  } idex_t;

  // A bubble is a fully cleared payload: no memory access, no writeback, no halt.
  localparam idex_t IDEX_BUBBLE = '0;

endpackage

// File: rtl/id_ex_latch_load_use_detect.sv
// Load-use hazard compare: the load sitting in EX writes a register that the
// instruction in ID is about to read. r0 never creates a dependency.
module id_ex_latch_load_use_detect
  import cpu_types_pkg::*;
(
  input  logic     run,
  input  logic     ex_dren,
  input  regbits_t ex_regdst,
  input  regbits_t id_rs,
  input  regbits_t id_rt,
  input  logic     id_rtused,
  output logic     hazard
);

  assign hazard = run && ex_dren && (ex_regdst != '0) &&
                  ((ex_regdst == id_rs) || (id_rtused && (ex_regdst == id_rt)));

endmodule

// File: rtl/id_ex_latch.sv
// ID/EX pipeline register with load-use bubble insertion and stall generation.
// Optional feature macro: IDEX_BUBBLE_CNT_EN adds a saturating count of
// hazard/stall bubbles on port bubble_cnt (flush bubbles are not counted).
//
//  state  | meaning
//  RUN    | normal capture of decode outputs each enabled edge
//  STALL  | inserting the remaining load-use bubbles, PC and IF/ID held
//  HALTED | halt captured; everything frozen until reset
module id_ex_latch
  import cpu_types_pkg::*;
#(
  parameter int STALL_CYCLES = 1
`ifdef IDEX_BUBBLE_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       exen,
  input  logic       flush,
  input  word_t      id_nPC,
  input  word_t      id_rdat1,
  input  word_t      id_rdat2,
  input  word_t      id_imm,
  input  word_t      id_shamt,
  input  word_t      id_lui,
  input  logic       id_dREN,
  input  logic       id_dWEN,
  input  logic       id_regWr,
  input  logic       id_halt,
  input  logic [2:0] id_regSel,
  input  logic [2:0] id_ALUSrc,
  input  aluop_t     id_ALUOp,
  input  regbits_t   id_regDst,
  input  regbits_t   id_rs,
  input  regbits_t   id_rt,
  input  logic       id_rtUsed,
  output word_t      ex_nPC,
  output word_t      ex_rdat1,
  output word_t      ex_rdat2,
  output word_t      ex_imm,
  output word_t      ex_shamt,
  output word_t      ex_lui,
  output logic       ex_dREN,
  output logic       ex_dWEN,
  output logic       ex_regWr,
  output logic       ex_halt,
  output logic [2:0] ex_regSel,
  output logic [2:0] ex_ALUSrc,
  output aluop_t     ex_ALUOp,
  output regbits_t   ex_regDst,
  output regbits_t   ex_rs,
  output regbits_t   ex_rt,
  output logic       stall
`ifdef IDEX_BUBBLE_CNT_EN
  , output logic [CNT_W-1:0] bubble_cnt
`endif
);

  // cnt holds the bubbles still owed after the one inserted on the hazard edge
  localparam logic [1:0] STALL_INIT = 2'(STALL_CYCLES - 1);

  idex_state_t state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  idex_t       ex_q, ex_d;
  idex_t       id_in;
  logic        hazard;

  // Gather decode outputs into one payload
  always_comb begin
    id_in        = IDEX_BUBBLE;
    id_in.npc    = id_nPC;
    id_in.dren   = id_dREN;
    id_in.dwen   = id_dWEN;
    id_in.regwr  = id_regWr;
    id_in.regsel = id_regSel;
    id_in.regdst = id_regDst;
    id_in.rs     = id_rs;
    id_in.rt     = id_rt;
    id_in.rdat1  = id_rdat1;
    id_in.rdat2  = id_rdat2;
    id_in.imm    = id_imm;
    id_in.shamt  = id_shamt;
    id_in.aluop  = id_ALUOp;
    id_in.alusrc = id_ALUSrc;
    id_in.halt   = id_halt;
    id_in.lui    = id_lui;
  end

  id_ex_latch_load_use_detect u_load_use_detect (
    .run       (state_q == RUN),
    .ex_dren   (ex_q.dren),
    .ex_regdst (ex_q.regdst),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_rtused (id_rtUsed),
    .hazard    (hazard)
  );

  // A flush in the same cycle as a hazard wins, so no stall is raised then
  assign stall = exen && !flush && (state_q != HALTED) && (hazard || (state_q == STALL));

  // Next-state and next-payload selection: HALTED > !exen > flush > hazard/STALL > load
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ex_d    = ex_q;
    if ((state_q != HALTED) && exen) begin
      if (flush) begin
        ex_d    = IDEX_BUBBLE;
        cnt_d   = '0;
        state_d = RUN;
      end else if (hazard) begin
        ex_d    = IDEX_BUBBLE;
        cnt_d   = STALL_INIT;
        state_d = (STALL_INIT != 2'd0) ? STALL : RUN;
      end else if (state_q == STALL) begin
        ex_d = IDEX_BUBBLE;
        if (cnt_q <= 2'd1) begin
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end else begin
        ex_d = id_in;
        if (id_halt) state_d = HALTED;
      end
    end
  end

  // State, counter and payload registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      cnt_q   <= '0;
      ex_q    <= IDEX_BUBBLE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ex_q    <= ex_d;
    end
  end

`ifdef IDEX_BUBBLE_CNT_EN
  logic [CNT_W-1:0] bcnt_q, bcnt_d;

  // Every edge taken while stall is high loads a hazard/STALL bubble
  always_comb begin
    bcnt_d = bcnt_q;
    if (stall && (bcnt_q != '1)) bcnt_d = bcnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // Saturating bubble counter, cleared only by reset
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) bcnt_q <= '0;
    else       bcnt_q <= bcnt_d;
  end

  assign bubble_cnt = bcnt_q;
`endif

  assign ex_nPC    = ex_q.npc;
  assign ex_rdat1  = ex_q.rdat1;
  assign ex_rdat2  = ex_q.rdat2;
  assign ex_imm    = ex_q.imm;
  assign ex_shamt  = ex_q.shamt;
  assign ex_lui    = ex_q.lui;
  assign ex_dREN   = ex_q.dren;
  assign ex_dWEN   = ex_q.dwen;
  assign ex_regWr  = ex_q.regwr;
  assign ex_halt   = ex_q.halt;
  assign ex_regSel = ex_q.regsel;
  assign ex_ALUSrc = ex_q.alusrc;
  assign ex_ALUOp  = ex_q.aluop;
  assign ex_regDst = ex_q.regdst;
  assign ex_rs     = ex_q.rs;
  assign ex_rt     = ex_q.rt;

endmodule
